// File: rtl/montgomery_mult_pkg.sv
// Shared RSA datapath definitions: default operand width, the FSM state encoding
// used by the multiplier and the exponentiation controller, and counter sizing.
package montgomery_mult_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOP  = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Bit-index counter width; kept at least one bit so tiny widths still elaborate.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/montgomery_mult_mont_step.sv
// One radix-2 Montgomery iteration: conditionally add b, make the sum even with n,
// then halve. Kept separate so the adder path can later be pipelined or widened.
module mont_step
  import montgomery_mult_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH+1:0] m,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] m_next
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] t_red;

  // With m < 2n the reduced sum stays below 4n, so WIDTH+2 bits never overflow.
  always_comb begin
    t      = m + (a_bit ? {2'b00, b} : '0);
    t_red  = t + (t[0] ? {2'b00, n} : '0);
    m_next = t_red >> 1;
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n, one bit of a per
// clock followed by a single conditional-subtraction cycle.
module montgomery_mult
  import montgomery_mult_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH+1:0] m;
  logic [WIDTH+1:0] m_next;
  logic [WIDTH-1:0] m_sub;
  logic [CW-1:0]    i;
  logic             last_iter;

  assign last_iter = (i == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign m_sub     = m[WIDTH-1:0] - n_reg;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .m      (m),
    .a_bit  (a_reg[i]),
    .b      (b_reg),
    .n      (n_reg),
    .m_next (m_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOOP;
      LOOP:    if (last_iter) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured only on acceptance; later input changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      n_reg  <= '0;
      m      <= '0;
      i      <= '0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            n_reg <= n;
            m     <= '0;
            i     <= '0;
          end
        end
        LOOP: begin
          m <= m_next;
          i <= i + CW'(1);
        end
        FINAL: begin
          // m < 2n here, so one subtraction brings it into [0, n).
          result <= (m >= {2'b00, n_reg}) ? m_sub : m[WIDTH-1:0];
          ready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult.sv
// Self-checking bench for montgomery_mult at WIDTH=8 and WIDTH=256 against a
// reference built from plain modular multiply followed by repeated modular halving.
module tb_montgomery_mult;

  localparam int WS = 8;
  localparam int WW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_s = 1'b0;
  logic [WS-1:0] a_s = '0;
  logic [WS-1:0] b_s = '0;
  logic [WS-1:0] n_s = '0;
  logic [WS-1:0] result_s;
  logic          ready_s;
  logic          busy_s;
  logic          start_w = 1'b0;
  logic [WW-1:0] a_w = '0;
  logic [WW-1:0] b_w = '0;
  logic [WW-1:0] n_w = '0;
  logic [WW-1:0] result_w;
  logic          ready_w;
  logic          busy_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  montgomery_mult #(.WIDTH(WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s), .n(n_s),
    .result(result_s), .ready(ready_s), .busy(busy_s)
  );

  montgomery_mult #(.WIDTH(WW)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .a(a_w), .b(b_w), .n(n_w),
    .result(result_w), .ready(ready_w), .busy(busy_w)
  );

  // a*b mod n by left-to-right doubling, then divide by 2^w via modular halving.
  function automatic logic [259:0] mont_ref(input logic [259:0] a, input logic [259:0] b,
                                            input logic [259:0] n, input int w);
    logic [259:0] p;
    p = '0;
    for (int k = w - 1; k >= 0; k--) begin
      p = p << 1;
      if (p >= n) p = p - n;
      if (a[k]) begin
        p = p + b;
        if (p >= n) p = p - n;
      end
    end
    for (int k = 0; k < w; k++) p = p[0] ? ((p + n) >> 1) : (p >> 1);
    return p;
  endfunction

  // Pre-processing stage value V = m * 2^w mod n.
  function automatic logic [259:0] to_mont(input logic [259:0] m, input logic [259:0] n,
                                           input int w);
    logic [259:0] v;
    v = m % n;
    for (int k = 0; k < w; k++) begin
      v = v << 1;
      if (v >= n) v = v - n;
    end
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit wide, input logic [255:0] a, input logic [255:0] b,
                                input logic [255:0] n, input bit hold);
    if (wide) begin
      a_w = a; b_w = b; n_w = n; start_w = 1'b1;
    end else begin
      a_s = a[WS-1:0]; b_s = b[WS-1:0]; n_s = n[WS-1:0]; start_s = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      start_s = 1'b0;
      start_w = 1'b0;
    end
  endtask

  task automatic wait_ready(input bit wide, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(wide ? ready_w : ready_s) && cyc < budget);
  endtask

  task automatic run_op(input string tag, input bit wide, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] n,
                        input logic [255:0] exp, input bit hold);
    int cyc;
    int w;
    w = wide ? WW : WS;
    apply_stimulus(wide, a, b, n, hold);
    check_output({tag, "_ready_low"}, 260'(wide ? ready_w : ready_s), 260'(0));
    check_output({tag, "_busy_high"}, 260'(wide ? busy_w : busy_s), 260'(1));
    wait_ready(wide, w + 20, cyc);
    check_output({tag, "_latency"}, 260'(cyc), 260'(w + 1));
    check_output({tag, "_result"}, wide ? 260'(result_w) : 260'(result_s), 260'(exp));
    check_output({tag, "_busy_low"}, 260'(wide ? busy_w : busy_s), 260'(0));
  endtask

  initial begin
    logic [259:0] exp;
    logic [255:0] ra;
    logic [255:0] rb;
    logic [255:0] rn;
    int           cyc;
    int           extra;

    #12;
    check_output("rst_result", 260'(result_s), 260'(0));
    check_output("rst_ready", 260'(ready_s), 260'(0));
    check_output("rst_busy", 260'(busy_s), 260'(0));
    check_output("rst_result_w", 260'(result_w), 260'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic_5x7", 0, 5, 7, 13, 1, 0);

    run_op("b2b_12x12", 0, 12, 12, 13, 3, 1);
    run_op("b2b_1x1", 0, 1, 1, 13, 3, 1);
    run_op("b2b_0x7", 0, 0, 7, 13, 0, 1);
    start_s = 1'b0;

    run_op("boundary_254", 0, 254, 254, 255, 1, 0);

    for (int k = 0; k < 8; k++) begin
      rn = 256'($urandom_range(3, 255) | 1);
      ra = 256'($urandom_range(0, 32'(rn) - 1));
      rb = 256'($urandom_range(0, 32'(rn) - 1));
      exp = mont_ref({4'b0, ra}, {4'b0, rb}, {4'b0, rn}, WS);
      $display("[TB] random8 a=%0d b=%0d n=%0d", ra, rb, rn);
      run_op("rand8", 0, ra, rb, rn, exp[255:0], 0);
    end

    $display("[TB] operand stability while busy");
    apply_stimulus(0, 5, 7, 13, 0);
    repeat (3) begin @(posedge clk); #1; end
    a_s = 1; b_s = 2; n_s = 11; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    wait_ready(0, 30, cyc);
    check_output("stable_latency", 260'(cyc), 260'(5));
    check_output("stable_result", 260'(result_s), 260'(1));
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready_s || busy_s) extra++;
    end
    check_output("stable_no_second_op", 260'(extra), 260'(0));

    $display("[TB] reset in the middle of an operation");
    apply_stimulus(0, 12, 12, 13, 0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_output("midrst_result", 260'(result_s), 260'(0));
    check_output("midrst_ready", 260'(ready_s), 260'(0));
    check_output("midrst_busy", 260'(busy_s), 260'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 0, 12, 12, 13, 3, 0);

    rn = (256'(1) << 255) + 256'h1D;
    exp = to_mont(260'h1234, {4'b0, rn}, WW);
    run_op("wide_from_mont", 1, exp[255:0], 1, rn, 256'h1234, 0);

    for (int k = 0; k < 3; k++) begin
      rn = rand256() | (256'(1) << 255) | 256'(1);
      ra = rand256() % rn;
      rb = rand256() % rn;
      exp = mont_ref({4'b0, ra}, {4'b0, rb}, {4'b0, rn}, WW);
      run_op("rand256", 1, ra, rb, rn, exp[255:0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
